// File: rtl/ysyx_22040931_lsu_if.sv
// Execute-side, memory-side and write-back handshakes of the LSU.
// slave is the LSU view, master is the surrounding pipeline/memory.
interface ysyx_22040931_lsu_if #(
  parameter int ADDR_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_memrop;
  logic [2:0]        in_memwop;
  logic [ADDR_W-1:0] in_addr;
  logic [63:0]       in_wdata;
  logic [4:0]        in_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [63:0]       mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_data;
  logic [4:0]        out_rd;
  logic              out_wen;
  logic              out_misalign;

  modport slave (
    input  in_valid, in_memrop, in_memwop,
    input  in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_req_valid, mem_req_we,
    output mem_req_addr, mem_req_wdata,
    output mem_req_wmask,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_rdata,
    output out_valid, out_data, out_rd,
    output out_wen, out_misalign,
    input  out_ready
  );

  modport master (
    output in_valid, in_memrop, in_memwop,
    output in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_req_valid, mem_req_we,
    input  mem_req_addr, mem_req_wdata,
    input  mem_req_wmask,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_rdata,
    input  out_valid, out_data, out_rd,
    input  out_wen, out_misalign,
    output out_ready
  );
endinterface

// File: rtl/ysyx_22040931_lsu.sv
// Load/store unit: one memory request per instruction, extended load
// result or store ack to write-back; non-memory ops pass through.
module ysyx_22040931_lsu #(
  parameter int ADDR_W = 64
) (
  input logic clk,
  input logic rst_n,
  ysyx_22040931_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0]  rop_q;
  logic [2:0]  off_q;
  logic        is_ld;
  logic        is_st;
  logic [2:0]  off;
  logic [1:0]  sz;
  logic [2:0]  amask;
  logic        mis;
  logic [7:0]  wmask;
  logic [63:0] sh;
  logic [63:0] ld_val;

  assign bus.in_ready      = (state == IDLE);
  assign bus.mem_req_valid = (state == REQ);
  assign bus.out_valid     = (state == DONE);

  // Load wins when both ops are set; 101-111 stores are non-memory.
  always_comb begin
    is_ld = |bus.in_memrop;
    is_st = !is_ld &&
      (bus.in_memwop inside {3'd1, 3'd2, 3'd3, 3'd4});
    off   = bus.in_addr[2:0];
    sz    = 2'd0;
    if (is_ld) begin
      case (bus.in_memrop)
        3'd2, 3'd6: sz = 2'd1;
        3'd3, 3'd7: sz = 2'd2;
        3'd4:       sz = 2'd3;
        default:    sz = 2'd0;
      endcase
    end else if (is_st) begin
      sz = 2'(bus.in_memwop - 3'd1);
    end
    case (sz)
      2'd1:    amask = 3'b001;
      2'd2:    amask = 3'b011;
      2'd3:    amask = 3'b111;
      default: amask = 3'b000;
    endcase
    case (sz)
      2'd1:    wmask = 8'h03 << off;
      2'd2:    wmask = 8'h0F << off;
      2'd3:    wmask = 8'hFF;
      default: wmask = 8'h01 << off;
    endcase
    mis = (is_ld || is_st) && ((off & amask) != 3'b000);
  end

  always_comb begin
    sh     = bus.mem_resp_rdata >> {off_q, 3'b000};
    ld_val = 64'd0;
    case (rop_q)
      3'd1: ld_val = {{56{sh[7]}}, sh[7:0]};
      3'd2: ld_val = {{48{sh[15]}}, sh[15:0]};
      3'd3: ld_val = {{32{sh[31]}}, sh[31:0]};
      3'd4: ld_val = sh;
      3'd5: ld_val = {56'd0, sh[7:0]};
      3'd6: ld_val = {48'd0, sh[15:0]};
      3'd7: ld_val = {32'd0, sh[31:0]};
      default: ld_val = 64'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (bus.in_valid)
          state_nxt = ((is_ld || is_st) && !mis)
                    ? REQ : DONE;
      REQ:
        if (bus.mem_req_ready)
          state_nxt = WAIT;
      WAIT:
        if (bus.mem_resp_valid)
          state_nxt = DONE;
      DONE:
        if (bus.out_ready)
          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rop_q             <= 3'd0;
      off_q             <= 3'd0;
      bus.mem_req_we    <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.mem_req_wdata <= 64'd0;
      bus.mem_req_wmask <= 8'd0;
      bus.out_data      <= 64'd0;
      bus.out_rd        <= 5'd0;
      bus.out_wen       <= 1'b0;
      bus.out_misalign  <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      rop_q             <= is_ld ? bus.in_memrop : 3'd0;
      off_q             <= off;
      bus.mem_req_we    <= is_st;
      bus.mem_req_addr  <= {bus.in_addr[ADDR_W-1:3], 3'b000};
      bus.mem_req_wdata <= is_st
        ? (bus.in_wdata << {off, 3'b000}) : 64'd0;
      bus.mem_req_wmask <= is_st ? wmask : 8'd0;
      bus.out_data      <= (is_ld || is_st)
        ? 64'd0 : 64'(bus.in_addr);
      bus.out_rd        <= bus.in_rd;
      bus.out_wen       <= !is_st && !mis;
      bus.out_misalign  <= mis;
    end else if (state == WAIT && bus.mem_resp_valid) begin
      if (rop_q != 3'd0)
        bus.out_data <= ld_val;
    end
  end

endmodule

// File: tb/tb_ysyx_22040931_lsu.sv
// Scoreboard bench for the LSU: random and directed ops against a
// byte-level reference model, with a simple memory responder.
module tb_ysyx_22040931_lsu;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_22040931_lsu_if #(.ADDR_W(AW)) bus();
  ysyx_22040931_lsu #(.ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    bit          chk_wdata;
  } req_t;

  typedef struct {
    logic [63:0] data;
    bit          chk_data;
    logic [4:0]  rd;
    logic        wen;
    logic        mis;
  } out_t;

  req_t rq[$];
  out_t oq[$];
  int n_cmp = 0;
  int n_bad = 0;

  bit          fix_en = 1'b0;
  logic [63:0] fix_val = 64'd0;
  int req_force = -1;
  int resp_force = -1;
  int out_stall = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur", name);
  endtask

  function automatic logic [63:0] pat(input logic [63:0] a);
    return (a * 64'h9E3779B97F4A7C15) ^ 64'h0123456789ABCDEF;
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return fix_en ? fix_val : pat(a);
  endfunction

  // Reference: byte-by-byte gather and arithmetic extension.
  task automatic expect_op(input logic [2:0] rop, input logic [2:0] wop,
                           input logic [63:0] addr,
                           input logic [63:0] wdata,
                           input logic [4:0] rd);
    int size, off, m;
    bit ld, st, sgn;
    logic [63:0] word, v, base;
    req_t r;
    out_t o;
    off  = int'(addr % 8);
    base = addr - 64'(off);
    ld   = (rop != 0);
    st   = !ld && wop >= 1 && wop <= 4;
    sgn  = ld && rop <= 4;
    size = 0;
    if (ld) begin
      if (rop == 1 || rop == 5) size = 1;
      else if (rop == 2 || rop == 6) size = 2;
      else if (rop == 3 || rop == 7) size = 4;
      else size = 8;
    end else if (st) begin
      size = 1 << (int'(wop) - 1);
    end
    o.rd = rd;
    if (!ld && !st) begin
      o.data = addr; o.chk_data = 1; o.wen = 1; o.mis = 0;
    end else if (off % size != 0) begin
      o.data = 0; o.chk_data = 1; o.wen = 0; o.mis = 1;
    end else begin
      m = ((1 << size) - 1) << off;
      r.addr      = base;
      r.we        = st;
      r.wmask     = st ? m[7:0] : 8'h00;
      r.wdata     = wdata << (8 * off);
      r.chk_wdata = st;
      rq.push_back(r);
      if (ld) begin
        word = mem_word(base);
        v = 0;
        for (int i = 0; i < size; i++)
          v |= ((word >> (8 * (off + i))) & 64'hFF) << (8 * i);
        if (sgn && size < 8 && v[8 * size - 1])
          v |= ~64'd0 << (8 * size);
        o.data = v; o.chk_data = 1; o.wen = 1; o.mis = 0;
      end else begin
        o.data = 0; o.chk_data = 0; o.wen = 0; o.mis = 0;
      end
    end
    oq.push_back(o);
  endtask

  // Call at posedge+#1; returns at posedge+#1 after acceptance.
  task automatic issue(input logic [2:0] rop, input logic [2:0] wop,
                       input logic [63:0] addr,
                       input logic [63:0] wdata,
                       input logic [4:0] rd);
    int t = 0;
    bit ok = 0;
    bus.in_valid  = 1'b1;
    bus.in_memrop = rop;
    bus.in_memwop = wop;
    bus.in_addr   = addr;
    bus.in_wdata  = wdata;
    bus.in_rd     = rd;
    while (!ok && t < 300) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      else t++;
    end
    if (ok) expect_op(rop, wop, addr, wdata, rd);
    else fail_now("in_ready_timeout");
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_memrop = 3'($urandom);
    bus.in_memwop = 3'($urandom);
    bus.in_addr   = {$urandom, $urandom};
    bus.in_wdata  = {$urandom, $urandom};
    bus.in_rd     = 5'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((rq.size() != 0 || oq.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Memory responder: random ready delay, random response delay.
  initial begin
    int ph = 0;
    int d = -1;
    logic [63:0] ra = 0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      case (ph)
        0: begin
          bus.mem_resp_valid = 1'b0;
          if (bus.mem_req_valid) begin
            if (d < 0)
              d = req_force >= 0 ? req_force : $urandom_range(0, 3);
            if (d == 0) begin
              bus.mem_req_ready  = 1'b1;
              bus.mem_resp_valid = 1'($urandom_range(0, 1));
              bus.mem_resp_rdata = {$urandom, $urandom};
              ra = bus.mem_req_addr;
              d  = -1;
              ph = 1;
            end else begin
              bus.mem_resp_valid = 1'($urandom_range(0, 1));
              bus.mem_resp_rdata = {$urandom, $urandom};
              d--;
            end
          end else if ($urandom_range(0, 7) == 0) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = {$urandom, $urandom};
          end
        end
        1, 2: begin
          bus.mem_req_ready  = 1'b0;
          bus.mem_resp_valid = 1'b0;
          if (ph == 1) begin
            d  = resp_force >= 0 ? resp_force : $urandom_range(0, 4);
            ph = 2;
          end
          if (d == 0) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = mem_word(ra);
            d  = -1;
            ph = 3;
          end else begin
            d--;
          end
        end
        default: begin
          bus.mem_resp_valid = 1'b0;
          bus.mem_resp_rdata = {$urandom, $urandom};
          ph = 0;
        end
      endcase
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_stall > 0) begin
        bus.out_ready = 1'b0;
        if (bus.out_valid) out_stall--;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: every cycle a side is valid it must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_req_valid) begin
          if (rq.size() == 0) begin
            fail_now("unexpected_mem_req");
          end else begin
            chk("req_we", 64'(bus.mem_req_we), 64'(rq[0].we));
            chk("req_addr", bus.mem_req_addr, rq[0].addr);
            chk("req_wmask", 64'(bus.mem_req_wmask), 64'(rq[0].wmask));
            if (rq[0].chk_wdata)
              chk("req_wdata", bus.mem_req_wdata, rq[0].wdata);
            if (bus.mem_req_ready) void'(rq.pop_front());
          end
        end
        if (bus.out_valid) begin
          if (oq.size() == 0) begin
            fail_now("unexpected_out_valid");
          end else begin
            chk("out_rd", 64'(bus.out_rd), 64'(oq[0].rd));
            chk("out_wen", 64'(bus.out_wen), 64'(oq[0].wen));
            chk("out_misalign", 64'(bus.out_misalign), 64'(oq[0].mis));
            if (oq[0].chk_data)
              chk("out_data", bus.out_data, oq[0].data);
            if (bus.out_ready) void'(oq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop, wop;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_memrop = 3'd0;
    bus.in_memwop = 3'd0;
    bus.in_addr   = '0;
    bus.in_wdata  = 64'd0;
    bus.in_rd     = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_req_wmask", 64'(bus.mem_req_wmask), 64'd0);
    chk("rst_req_addr", bus.mem_req_addr, 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fix_en  = 1'b1;
    fix_val = 64'h1122_3344_8566_7788;
    issue(3'd1, 3'd0, 64'h8000_0003, 64'd0, 5'd7);
    wait_idle();
    issue(3'd6, 3'd0, 64'h8000_0006, 64'd0, 5'd9);
    wait_idle();
    issue(3'd3, 3'd0, 64'h8000_0004, 64'd0, 5'd10);
    wait_idle();
    issue(3'd0, 3'd2, 64'h8000_0002, 64'hABCD, 5'd11);
    wait_idle();

    issue(3'd3, 3'd0, 64'h8000_0002, 64'd0, 5'd12);
    @(negedge clk);
    chk("mis_out_valid", 64'(bus.out_valid), 64'd1);
    chk("mis_flag", 64'(bus.out_misalign), 64'd1);
    chk("mis_no_req", 64'(bus.mem_req_valid), 64'd0);
    wait_idle();

    req_force = 3;
    out_stall = 2;
    issue(3'd4, 3'd0, 64'h8000_0008, 64'd0, 5'd13);
    wait_idle();
    req_force = -1;
    out_stall = 0;

    req_force  = 0;
    resp_force = 8;
    issue(3'd3, 3'd0, 64'h8000_0010, 64'd0, 5'd5);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("arst_req_we", 64'(bus.mem_req_we), 64'd0);
    chk("arst_req_addr", bus.mem_req_addr, 64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", bus.out_data, 64'd0);
    chk("arst_out_rd", 64'(bus.out_rd), 64'd0);
    chk("arst_out_wen", 64'(bus.out_wen), 64'd0);
    rq.delete();
    oq.delete();
    req_force  = -1;
    resp_force = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("late_resp_out_valid", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    issue(3'd0, 3'd0, 64'h1234, 64'd0, 5'd3);
    @(negedge clk);
    chk("pass_out_valid", 64'(bus.out_valid), 64'd1);
    chk("pass_out_data", bus.out_data, 64'h1234);
    wait_idle();

    fix_en = 1'b0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: begin rop = 3'($urandom_range(1, 7)); wop = 3'd0; end
        1: begin rop = 3'd0; wop = 3'($urandom_range(1, 7)); end
        2: begin
          rop = 3'($urandom_range(1, 7));
          wop = 3'($urandom_range(1, 7));
        end
        default: begin rop = 3'd0; wop = 3'd0; end
      endcase
      issue(rop, wop, {32'd0, 32'h8000_0000 + $urandom_range(0, 4095)},
            {$urandom, $urandom}, 5'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    chk("req_queue_empty", 64'(rq.size()), 64'd0);
    chk("out_queue_empty", 64'(oq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
